// File: rtl/zero_exec_pkg.sv
// Shared types and instruction field layout for the Zero program executor.
// Instruction word, MSB first: {op[3:0], tgt[ADDR-1:0], ia, a[WIDTH-1:0], ib, b[WIDTH-1:0]}.
package zero_exec_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_MOV  = 4'd3,
        OP_OUT  = 4'd4,
        OP_IN   = 4'd5,
        OP_JEQ  = 4'd6,
        OP_JMP  = 4'd7,
        OP_HALT = 4'd8
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_EXEC,
        S_WAIT_OUT,
        S_WAIT_IN,
        S_DONE
    } state_e;

    // Field offsets as functions of the data width and local address width.
    function automatic int unsigned instr_w(input int unsigned w, input int unsigned a);
        return OP_W + a + 2 + 2 * w;
    endfunction

    function automatic int unsigned off_ib(input int unsigned w);
        return w;
    endfunction

    function automatic int unsigned off_a(input int unsigned w);
        return w + 1;
    endfunction

    function automatic int unsigned off_ia(input int unsigned w);
        return 2 * w + 1;
    endfunction

    function automatic int unsigned off_tgt(input int unsigned w);
        return 2 * w + 2;
    endfunction

    function automatic int unsigned off_op(input int unsigned w, input int unsigned a);
        return 2 * w + 2 + a;
    endfunction

endpackage

// File: rtl/zero_out_fifo.sv
// Out-channel FIFO, WIDTH x DEPTH (DEPTH a power of 2).
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i synchronous empty;
// push_i/data_i write side (accepted when not full or when popping in the same cycle);
// pop_i/data_o read side; full_o/empty_o flags.
module zero_out_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    // Pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage is reset so the head reads 0 straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/zero_exec_core.sv
// Executor for loaded Zero programs: code ROM (loadable while not busy) run against a
// local memory, with handshaked in channel and buffered out channel.
// Ports: clock_i/reset_ni clock and async active-low reset; load_* code write port;
// start_i run pulse; in_valid_i/in_data_i/in_ready_o input channel; out_valid_o/
// out_data_o/out_ready_i output channel; busy_o/finished_o/success_o/error_o status;
// steps_o executed-instruction count.
module zero_exec_core
    import zero_exec_pkg::*;
#(
    parameter  int unsigned WIDTH     = 12,
    parameter  int unsigned ADDR      = 8,
    parameter  int unsigned PC_W      = 6,
    parameter  int unsigned OUT_DEPTH = 4,
    parameter  int unsigned MAX_STEPS = 1000,
    localparam int unsigned INSTR_W   = instr_w(WIDTH, ADDR)
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    input  logic               load_valid_i,
    input  logic [PC_W-1:0]    load_addr_i,
    input  logic [INSTR_W-1:0] load_data_i,
    input  logic               start_i,
    input  logic               in_valid_i,
    input  logic [WIDTH-1:0]   in_data_i,
    output logic               in_ready_o,
    output logic               out_valid_o,
    output logic [WIDTH-1:0]   out_data_o,
    input  logic               out_ready_i,
    output logic               busy_o,
    output logic               finished_o,
    output logic               success_o,
    output logic               error_o,
    output logic [31:0]        steps_o
);

    localparam int unsigned IB_BIT  = off_ib(WIDTH);
    localparam int unsigned A_LSB   = off_a(WIDTH);
    localparam int unsigned IA_BIT  = off_ia(WIDTH);
    localparam int unsigned TGT_LSB = off_tgt(WIDTH);
    localparam int unsigned OP_LSB  = off_op(WIDTH, ADDR);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [31:0]        steps_q, steps_d;
    logic               error_q, error_d;
    logic [ADDR-1:0]    clr_q, clr_d;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] code_mem [2**PC_W];
    logic [WIDTH-1:0]   lmem_q [2**ADDR];

    logic [3:0]         op;
    logic [ADDR-1:0]    tgt;
    logic               ia, ib;
    logic [WIDTH-1:0]   a_f, b_f, a_val, b_val;

    logic               mem_we;
    logic [ADDR-1:0]    mem_wa;
    logic [WIDTH-1:0]   mem_wd;
    logic               fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty, can_push;
    logic               retire, jump, stop, illegal;
    logic               in_ready_c, busy_c, finished_c, success_c;

    // Instruction decode and operand fetch (immediate or local memory).
    assign op    = instr_q[OP_LSB +: OP_W];
    assign tgt   = instr_q[TGT_LSB +: ADDR];
    assign ia    = instr_q[IA_BIT];
    assign a_f   = instr_q[A_LSB +: WIDTH];
    assign ib    = instr_q[IB_BIT];
    assign b_f   = instr_q[0 +: WIDTH];
    assign a_val = ia ? a_f : lmem_q[a_f[ADDR-1:0]];
    assign b_val = ib ? b_f : lmem_q[b_f[ADDR-1:0]];

    assign fifo_pop = out_ready_i && !fifo_empty;
    assign can_push = !fifo_full || fifo_pop;

    // State register.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next state plus datapath next values.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        steps_d    = steps_q;
        error_d    = error_q;
        clr_d      = clr_q;
        mem_we     = 1'b0;
        mem_wa     = tgt;
        mem_wd     = '0;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        in_ready_c = 1'b0;
        retire     = 1'b0;
        jump       = 1'b0;
        stop       = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d    = S_CLEAR;
                    pc_d       = '0;
                    steps_d    = '0;
                    error_d    = 1'b0;
                    clr_d      = '0;
                    fifo_flush = 1'b1;
                end
            end
            S_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = clr_q;
                clr_d  = clr_q + ADDR'(1);
                if (clr_q == '1) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_NOP: retire = 1'b1;
                    OP_ADD: begin mem_we = 1'b1; mem_wd = a_val + b_val; retire = 1'b1; end
                    OP_SUB: begin mem_we = 1'b1; mem_wd = a_val - b_val; retire = 1'b1; end
                    OP_MOV: begin mem_we = 1'b1; mem_wd = a_val; retire = 1'b1; end
                    OP_OUT: begin
                        if (can_push) begin fifo_push = 1'b1; retire = 1'b1; end
                        else          state_d = S_WAIT_OUT;
                    end
                    OP_IN: begin
                        if (in_valid_i) begin
                            mem_we = 1'b1; mem_wd = in_data_i; in_ready_c = 1'b1; retire = 1'b1;
                        end else begin
                            state_d = S_WAIT_IN;
                        end
                    end
                    OP_JEQ:  begin jump = (a_val == b_val); retire = 1'b1; end
                    OP_JMP:  begin jump = 1'b1; retire = 1'b1; end
                    OP_HALT: begin stop = 1'b1; retire = 1'b1; end
                    default: begin illegal = 1'b1; retire = 1'b1; end
                endcase
            end
            S_WAIT_OUT: begin
                if (can_push) begin fifo_push = 1'b1; retire = 1'b1; end
            end
            S_WAIT_IN: begin
                if (in_valid_i) begin
                    mem_we = 1'b1; mem_wd = in_data_i; in_ready_c = 1'b1; retire = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Completion of an instruction: count it, then pick the successor.
        if (retire) begin
            steps_d = steps_q + 32'd1;
            if (illegal) begin
                error_d = 1'b1;
                state_d = S_DONE;
            end else if (stop) begin
                state_d = S_DONE;
            end else if (steps_d == 32'(MAX_STEPS)) begin
                error_d = 1'b1;
                state_d = S_DONE;
            end else if (jump) begin
                pc_d    = PC_W'(tgt);
                state_d = S_FETCH;
            end else begin
                pc_d    = pc_q + PC_W'(1);
                state_d = (pc_q == '1) ? S_DONE : S_FETCH;
            end
        end
    end

    // Status decode.
    always_comb begin
        busy_c     = 1'b0;
        finished_c = 1'b0;
        success_c  = 1'b0;
        case (state_q)
            S_CLEAR, S_FETCH, S_EXEC, S_WAIT_OUT, S_WAIT_IN: busy_c = 1'b1;
            S_DONE: begin
                finished_c = 1'b1;
                success_c  = !error_q;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pc_q    <= '0;
            steps_q <= '0;
            error_q <= 1'b0;
            clr_q   <= '0;
            instr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            steps_q <= steps_d;
            error_q <= error_d;
            clr_q   <= clr_d;
            if (state_q == S_FETCH) instr_q <= code_mem[pc_q];
        end
    end

    // Code memory survives reset; writes are blocked during a run.
    always_ff @(posedge clock_i) begin
        if (load_valid_i && !busy_c) code_mem[load_addr_i] <= load_data_i;
    end

    // Local memory is zeroed by the CLEAR sweep, not by reset.
    always_ff @(posedge clock_i) begin
        if (mem_we) lmem_q[mem_wa] <= mem_wd;
    end

    zero_out_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk_i   (clock_i),
        .rst_ni  (reset_ni),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .data_i  (a_val),
        .pop_i   (fifo_pop),
        .data_o  (out_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready_o  = in_ready_c;
    assign out_valid_o = !fifo_empty;
    assign busy_o      = busy_c;
    assign finished_o  = finished_c;
    assign success_o   = success_c;
    assign error_o     = error_q;
    assign steps_o     = steps_q;

endmodule
